// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer in front of a UART transmitter.
// Producers push bytes at any rate. The sequencer issues one registered trmt pulse
// per byte and then waits for a rising edge on the transmitter's sticky tx_done.
module uart_tx_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic          trmt,
    output logic [7:0]    tx_data,
    input  logic          tx_done,
    output logic          busy
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           tx_done_q;
    logic           done_rise;
    logic           pop;
    logic           push;
    logic           drop;

    // Occupancy update, clamped so the count can never leave 0..DEPTH.
    function automatic logic [AW:0] count_step(input logic [AW:0] cur,
                                               input logic inc,
                                               input logic dec);
        logic [AW:0] res;
        res = cur;
        if (inc && !dec && cur != DEPTH_C) begin
            res = cur + (AW+1)'(1);
        end else if (dec && !inc && cur != '0) begin
            res = cur - (AW+1)'(1);
        end
        return res;
    endfunction

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign done_rise = tx_done & ~tx_done_q;
    // The sequencer only enters LAUNCH with data queued; the guard keeps pop safe anyway.
    assign pop       = (state == LAUNCH) & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full queue is still taken.
    assign push      = wr_en & (~full | pop);
    assign drop      = wr_en & full & ~pop;
    assign busy      = (state != IDLE) | ~empty;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_step(count, push, pop);
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Delayed copy of tx_done so only its rising edge releases the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
        end
    end

    // Launch outputs: byte captured on pop, trmt pulses the cycle after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= 8'hFF;
            trmt    <= 1'b0;
        end else begin
            trmt <= pop;
            if (pop) begin
                tx_data <= mem[rptr];
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next-state: launch when data waits, then hold until the frame completes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
